// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared debouncer state encoding and default timing constants.
package key_cond_pkg;
    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_e;
    localparam int TICK_DIV_DEF = 10000;
    localparam int DEPTH_DEF    = 11;
    localparam int HOLD_DEF     = 1000;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock into a registered one-cycle sample strobe.
module tick_prescaler
    import key_cond_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;
    always_comb begin
        tick_d = pcnt_q == P_LAST;
        pcnt_d = tick_d ? '0 : pcnt_q + 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end
    assign tick_o = tick_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces a push-button into level, press/release strobes and a long-press hold.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int HOLD_TICKS = HOLD_DEF
) (
    input  logic mhz_i,
    input  logic reset_i,
    input  logic ps3_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o,
    output logic tick_o
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [SW-1:0] S_LAST = SW'(DEPTH - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
    logic          s1_q, s2_q, tick;
    state_e        state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d, press_q, press_d, release_q, release_d;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i (mhz_i),
        .rst_i (reset_i),
        .tick_o(tick)
    );
    // scnt counts agreeing samples already seen, so the DEPTH-th one is the transition
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                S_LOW: if (s2_q) begin
                    state_d = S_RISE;
                    scnt_d  = SW'(1);
                end
                S_RISE: if (!s2_q) begin
                    state_d = S_LOW;
                    scnt_d  = '0;
                end else if (scnt_q == S_LAST) begin
                    state_d = S_HIGH;
                    scnt_d  = '0;
                    press_d = 1'b1;
                end else scnt_d = scnt_q + 1'b1;
                S_HIGH: if (!s2_q) begin
                    state_d = S_FALL;
                    scnt_d  = SW'(1);
                end
                S_FALL: if (s2_q) begin
                    state_d = S_HIGH;
                    scnt_d  = '0;
                end else if (scnt_q == S_LAST) begin
                    state_d   = S_LOW;
                    scnt_d    = '0;
                    release_d = 1'b1;
                end else scnt_d = scnt_q + 1'b1;
                default: state_d = S_LOW;
            endcase
        end
        level_d = state_d == S_HIGH || state_d == S_FALL;
        // clearing on level_d drops hold together with release; gating on level_q skips the press tick
        hcnt_d  = !level_d ? '0 : (tick && level_q && hcnt_q != H_MAX) ? hcnt_q + 1'b1 : hcnt_q;
    end
    always_ff @(posedge mhz_i) begin
        if (reset_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= S_LOW;
            scnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= ps3_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end
    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hcnt_q == H_MAX;
    assign tick_o    = tick;
endmodule
